i2c_slave: RTL and testbench

Byte-oriented I2C target: the responder on the same two-wire bus driven by `i2c_master`. It oversamples SCL/SDA on the system clock, detects START/STOP, matches a fixed 7-bit address, ACKs, and bridges bus transfers to a simple 8-bit register-access port. The first written byte after the address is a register pointer. Later writes and reads use that pointer and auto-increment it. No clock stretching.

---
 rtl/i2c_slave_pkg.sv | 22 ++
 rtl/i2c_slave_if.sv | 31 +++
 rtl/i2c_slave_sync_edge.sv | 26 ++
 rtl/i2c_slave.sv | 193 +++++++++++++++++++
 tb/tb_i2c_slave.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_slave_pkg.sv
// i2c_slave_pkg: shared definitions for the I2C target.
//   state_t  - protocol FSM states (3-bit encoding)
//   RW_BIT   - position of the R/W flag inside the address byte
//   I2C_ACK / I2C_NACK - bus levels of the acknowledge bit
package i2c_slave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_WAIT_STOP
    } state_t;

    localparam int unsigned RW_BIT   = 0;
    localparam logic        I2C_ACK  = 1'b0;
    localparam logic        I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_slave_if.sv
// i2c_slave_if: register-access port between the I2C target and user logic.
//   ow_busy    - target is addressed and transferring
//   ow_addr    - current register pointer
//   ow_wr_en   - one-cycle write strobe
//   ow_wr_data - write data, valid with ow_wr_en
//   iw_rd_data - read data for ow_addr, supplied by user logic
interface i2c_slave_if;

    logic       ow_busy;
    logic [7:0] ow_addr;
    logic       ow_wr_en;
    logic [7:0] ow_wr_data;
    logic [7:0] iw_rd_data;

    modport slave (
        output ow_busy,
        output ow_addr,
        output ow_wr_en,
        output ow_wr_data,
        input  iw_rd_data
    );

    modport master (
        input  ow_busy,
        input  ow_addr,
        input  ow_wr_en,
        input  ow_wr_data,
        output iw_rd_data
    );

endinterface

// File: rtl/i2c_slave_sync_edge.sv
// i2c_sync_edge: 2-flop synchronizer plus registered copy for edge detect.
//   iw_clk, iw_reset_n - system clock, async active-low reset (flops reset to 1)
//   iw_in              - asynchronous bus pin
//   ow_level           - synchronized level
//   ow_rise / ow_fall  - one-cycle pulses on synchronized edges
module i2c_sync_edge (
    input  logic iw_clk,
    input  logic iw_reset_n,
    input  logic iw_in,
    output logic ow_level,
    output logic ow_rise,
    output logic ow_fall
);

    logic [2:0] r_sync;

    always_ff @(posedge iw_clk or negedge iw_reset_n) begin
        if (!iw_reset_n) r_sync <= '1;
        else             r_sync <= {r_sync[1:0], iw_in};
    end

    assign ow_level = r_sync[1];
    assign ow_rise  =  r_sync[1] & ~r_sync[2];
    assign ow_fall  = ~r_sync[1] &  r_sync[2];

endmodule

// File: rtl/i2c_slave.sv
// i2c_slave: byte-oriented I2C target with register-pointer access.
//   iw_clk      - system clock (>= 16x SCL)
//   iw_reset_n  - asynchronous active-low reset
//   io_i2c_scl  - bus clock, sampled only
//   io_i2c_sda  - open-drain data, driven low when r_sda_oe
//   bus         - register-access port (i2c_slave_if.slave)
// First written byte after the address sets the pointer; later data bytes
// and read bytes use it and auto-increment it. No clock stretching.
module i2c_slave
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0] ADDR = 7'h42
) (
    input  logic              iw_clk,
    input  logic              iw_reset_n,
    input  wire               io_i2c_scl,
    inout  wire               io_i2c_sda,
    i2c_slave_if.slave        bus
);

    logic scl_level, scl_rise, scl_fall;
    logic sda_level, sda_rise, sda_fall;

    i2c_sync_edge u_scl (
        .iw_clk(iw_clk), .iw_reset_n(iw_reset_n), .iw_in(io_i2c_scl),
        .ow_level(scl_level), .ow_rise(scl_rise), .ow_fall(scl_fall)
    );

    i2c_sync_edge u_sda (
        .iw_clk(iw_clk), .iw_reset_n(iw_reset_n), .iw_in(io_i2c_sda),
        .ow_level(sda_level), .ow_rise(sda_rise), .ow_fall(sda_fall)
    );

    logic start_det, stop_det;
    assign start_det = sda_fall & scl_level;
    assign stop_det  = sda_rise & scl_level;

    state_t     r_state, state_n;
    logic [2:0] r_bit_cnt, bit_cnt_n;
    logic [7:0] r_shift, shift_n;
    logic       r_sda_oe, sda_oe_n;
    logic       r_busy, busy_n;
    logic [7:0] r_addr, addr_n;
    logic       r_wr_en, wr_en_n;
    logic [7:0] r_wr_data, wr_data_n;
    logic       r_first, first_n;
    logic       r_rw, rw_n;
    logic       r_inc, inc_n;

    always_ff @(posedge iw_clk or negedge iw_reset_n) begin
        if (!iw_reset_n) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_addr    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_data <= '0;
            r_first   <= 1'b0;
            r_rw      <= 1'b0;
            r_inc     <= 1'b0;
        end else begin
            r_state   <= state_n;
            r_bit_cnt <= bit_cnt_n;
            r_shift   <= shift_n;
            r_sda_oe  <= sda_oe_n;
            r_busy    <= busy_n;
            r_addr    <= addr_n;
            r_wr_en   <= wr_en_n;
            r_wr_data <= wr_data_n;
            r_first   <= first_n;
            r_rw      <= rw_n;
            r_inc     <= inc_n;
        end
    end

    always_comb begin
        state_n   = r_state;
        bit_cnt_n = r_bit_cnt;
        shift_n   = r_shift;
        sda_oe_n  = r_sda_oe;
        busy_n    = r_busy;
        addr_n    = r_addr;
        wr_en_n   = 1'b0;
        wr_data_n = r_wr_data;
        first_n   = r_first;
        rw_n      = r_rw;
        inc_n     = 1'b0;

        // Pointer bump lands the cycle after the write strobe.
        if (r_inc) addr_n = r_addr + 8'd1;

        if (start_det) begin
            state_n   = ST_ADDR;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
        end else if (stop_det) begin
            state_n  = ST_IDLE;
            sda_oe_n = 1'b0;
            busy_n   = 1'b0;
        end else begin
            case (r_state)
                ST_ADDR: if (scl_rise) begin
                    shift_n   = {r_shift[6:0], sda_level};
                    bit_cnt_n = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        if (shift_n[7:1] == ADDR) begin
                            state_n = ST_ADDR_ACK;
                            rw_n    = shift_n[RW_BIT];
                            first_n = 1'b1;
                        end else begin
                            state_n = ST_WAIT_STOP;
                        end
                    end
                end
                // The ACK slot spans two SCL falls: the first starts the
                // drive, the second ends it (oe itself tells them apart).
                ST_ADDR_ACK: if (scl_fall) begin
                    if (!r_sda_oe) begin
                        sda_oe_n = 1'b1;
                        busy_n   = 1'b1;
                    end else if (r_rw) begin
                        shift_n  = bus.iw_rd_data;
                        sda_oe_n = ~bus.iw_rd_data[7];
                        state_n  = ST_RD_BYTE;
                    end else begin
                        sda_oe_n = 1'b0;
                        state_n  = ST_WR_BYTE;
                    end
                end
                ST_WR_BYTE: if (scl_rise) begin
                    shift_n   = {r_shift[6:0], sda_level};
                    bit_cnt_n = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        state_n = ST_WR_ACK;
                        if (r_first) begin
                            addr_n  = shift_n;
                            first_n = 1'b0;
                        end else begin
                            wr_en_n   = 1'b1;
                            wr_data_n = shift_n;
                            inc_n     = 1'b1;
                        end
                    end
                end
                ST_WR_ACK: if (scl_fall) begin
                    if (!r_sda_oe) begin
                        sda_oe_n = 1'b1;
                    end else begin
                        sda_oe_n = 1'b0;
                        state_n  = ST_WR_BYTE;
                    end
                end
                // Counter is 0 again at the fall after the 8th rise.
                ST_RD_BYTE: begin
                    if (scl_rise) bit_cnt_n = r_bit_cnt + 3'd1;
                    if (scl_fall) begin
                        if (r_bit_cnt == 3'd0) begin
                            sda_oe_n = 1'b0;
                            state_n  = ST_RD_ACK;
                        end else begin
                            sda_oe_n = ~r_shift[3'd7 - r_bit_cnt];
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        addr_n = r_addr + 8'd1;
                        if (sda_level == I2C_NACK) begin
                            state_n = ST_WAIT_STOP;
                            busy_n  = 1'b0;
                        end
                    end
                    if (scl_fall) begin
                        shift_n  = bus.iw_rd_data;
                        sda_oe_n = ~bus.iw_rd_data[7];
                        state_n  = ST_RD_BYTE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io_i2c_sda     = r_sda_oe ? 1'b0 : 1'bz;
    assign bus.ow_busy    = r_busy;
    assign bus.ow_addr    = r_addr;
    assign bus.ow_wr_en   = r_wr_en;
    assign bus.ow_wr_data = r_wr_data;

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: directed bench for i2c_slave acting as the bus master.
module tb_i2c_slave;
    import i2c_slave_pkg::*;

    localparam int T = 50;   // quarter SCL period; SCL = 20 system clocks

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl = 1'b1;
    logic m_sda_low = 1'b0;
    wire  sda;

    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    i2c_slave_if bus ();
    assign bus.iw_rd_data = ~bus.ow_addr;

    i2c_slave #(.ADDR(7'h42)) dut (
        .iw_clk(clk),
        .iw_reset_n(rst_n),
        .io_i2c_scl(scl),
        .io_i2c_sda(sda),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // write-strobe log
    int         wr_cnt = 0;
    logic [7:0] log_addr [16];
    logic [7:0] log_data [16];

    always @(negedge clk) begin
        if (bus.ow_wr_en === 1'b1) begin
            if (wr_cnt < 16) begin
                log_addr[wr_cnt] = bus.ow_addr;
                log_data[wr_cnt] = bus.ow_wr_data;
            end
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_start();
        m_sda_low = 1'b0; #T;
        scl = 1'b1;       #T;
        m_sda_low = 1'b1; #T;
        scl = 1'b0;       #T;
    endtask

    task automatic bus_stop();
        m_sda_low = 1'b1; #T;
        scl = 1'b1;       #T;
        m_sda_low = 1'b0; #T;
    endtask

    task automatic send_bit(input logic b);
        m_sda_low = ~b; #T;
        scl = 1'b1;     #T;
        #T;
        scl = 1'b0;     #T;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_sda_low = 1'b0; #T;
        scl = 1'b1;       #T;
        ack = sda;        #T;
        scl = 1'b0;       #T;
    endtask

    task automatic read_byte(output logic [7:0] b);
        m_sda_low = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            #T; scl = 1'b1;
            #T; b[i] = sda;
            #T; scl = 1'b0;
            #T;
        end
    endtask

    task automatic master_ack(input logic nack);
        m_sda_low = ~nack; #T;
        scl = 1'b1;        #T;
        #T;
        scl = 1'b0;        #T;
    endtask

    logic       ack;
    logic [7:0] rb;

    initial begin
        // reset state
        #100;
        chk("rst_busy", bus.ow_busy, 0);
        chk("rst_addr", bus.ow_addr, 8'h00);
        chk("rst_wr_en", bus.ow_wr_en, 0);
        chk("rst_wr_data", bus.ow_wr_data, 8'h00);
        chk("rst_sda", sda, 1);
        rst_n = 1'b1;
        #100;

        // single-byte write
        bus_start();
        write_byte(8'h84, ack); chk("w1_addr_ack", ack, 0);
        chk("w1_busy", bus.ow_busy, 1);
        write_byte(8'h10, ack); chk("w1_ptr_ack", ack, 0);
        chk("w1_ptr", bus.ow_addr, 8'h10);
        chk("w1_no_wr_yet", wr_cnt, 0);
        write_byte(8'hA5, ack); chk("w1_data_ack", ack, 0);
        chk("w1_wr_cnt", wr_cnt, 1);
        chk("w1_wr_addr", log_addr[0], 8'h10);
        chk("w1_wr_data", log_data[0], 8'hA5);
        chk("w1_addr_inc", bus.ow_addr, 8'h11);
        bus_stop(); #200;
        chk("w1_busy_stop", bus.ow_busy, 0);

        // wrong address
        bus_start();
        write_byte(8'hA0, ack); chk("wa_nack", ack, 1);
        chk("wa_busy", bus.ow_busy, 0);
        write_byte(8'h33, ack); chk("wa_b2_nack", ack, 1);
        write_byte(8'h44, ack);
        chk("wa_no_wr", wr_cnt, 1);
        bus_stop(); #200;
        chk("wa_idle", dut.r_state, ST_IDLE);
        chk("wa_addr", bus.ow_addr, 8'h11);

        // random read with repeated START
        bus_start();
        write_byte(8'h84, ack); chk("rd_addr_ack", ack, 0);
        write_byte(8'h20, ack); chk("rd_ptr_ack", ack, 0);
        chk("rd_ptr", bus.ow_addr, 8'h20);
        bus_start();
        write_byte(8'h85, ack); chk("rd_raddr_ack", ack, 0);
        read_byte(rb); chk("rd_byte0", rb, 8'hDF);
        master_ack(1'b0);
        read_byte(rb); chk("rd_byte1", rb, 8'hDE);
        master_ack(1'b1);
        #T;
        chk("rd_sda_rel", sda, 1);
        chk("rd_addr_end", bus.ow_addr, 8'h22);
        chk("rd_busy_nack", bus.ow_busy, 0);
        chk("rd_no_wr", wr_cnt, 1);
        bus_stop(); #200;

        // pointer wrap
        bus_start();
        write_byte(8'h84, ack);
        write_byte(8'hFF, ack); chk("wrap_ptr", bus.ow_addr, 8'hFF);
        write_byte(8'h11, ack); chk("wrap_d0_ack", ack, 0);
        write_byte(8'h22, ack); chk("wrap_d1_ack", ack, 0);
        bus_stop(); #200;
        chk("wrap_cnt", wr_cnt, 3);
        chk("wrap_a0", log_addr[1], 8'hFF);
        chk("wrap_d0", log_data[1], 8'h11);
        chk("wrap_a1", log_addr[2], 8'h00);
        chk("wrap_d1", log_data[2], 8'h22);
        chk("wrap_final", bus.ow_addr, 8'h01);

        // async reset while driving the address ACK
        bus_start();
        for (int i = 7; i >= 0; i--) send_bit(8'h84 >> i);
        m_sda_low = 1'b0; #2;
        chk("ar_ack_driven", sda, 0);
        rst_n = 1'b0; #1;
        chk("ar_ack_sda_rel", sda, 1);
        chk("ar_busy", bus.ow_busy, 0);
        chk("ar_addr", bus.ow_addr, 8'h00);
        chk("ar_wr_data", bus.ow_wr_data, 8'h00);
        #27; rst_n = 1'b1; #20;
        bus_stop(); #200;

        // async reset while driving a read bit (pointer 0x80 -> data 0x7F, MSB 0)
        bus_start();
        write_byte(8'h84, ack);
        write_byte(8'h80, ack);
        bus_start();
        write_byte(8'h85, ack); chk("ar2_raddr_ack", ack, 0);
        #2;
        chk("ar2_bit_driven", sda, 0);
        rst_n = 1'b0; #1;
        chk("ar2_sda_rel", sda, 1);
        chk("ar2_addr", bus.ow_addr, 8'h00);
        #27; rst_n = 1'b1; #20;
        bus_stop(); #200;

        // normal write after reset
        bus_start();
        write_byte(8'h84, ack); chk("pr_addr_ack", ack, 0);
        write_byte(8'h05, ack);
        write_byte(8'h5A, ack); chk("pr_data_ack", ack, 0);
        bus_stop(); #200;
        chk("pr_cnt", wr_cnt, 4);
        chk("pr_wa", log_addr[3], 8'h05);
        chk("pr_wd", log_data[3], 8'h5A);
        chk("pr_addr", bus.ow_addr, 8'h06);

        // START in the middle of a data byte
        bus_start();
        write_byte(8'h84, ack);
        write_byte(8'h40, ack);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        bus_start();
        chk("ms_no_wr", wr_cnt, 4);
        chk("ms_addr", bus.ow_addr, 8'h40);
        write_byte(8'h84, ack); chk("ms_addr_ack", ack, 0);
        write_byte(8'h50, ack); chk("ms_ptr", bus.ow_addr, 8'h50);
        write_byte(8'h66, ack);
        bus_stop(); #200;
        chk("ms_cnt", wr_cnt, 5);
        chk("ms_wa", log_addr[4], 8'h50);
        chk("ms_wd", log_data[4], 8'h66);
        chk("ms_final", bus.ow_addr, 8'h51);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
